// File: rtl/scan_test_ctrl_if.sv
// Scan test controller bus: start/pattern request, chain scan signals and
// result reporting. The expected/fail pair exists only when
// SCAN_TEST_CTRL_COMPARE_EN is defined.
interface scan_test_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 14
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern;
  logic                 scan_out;
  logic                 test_se;
  logic                 test_si;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] response;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected;
  logic                 fail;

  modport slave (
    input  start, pattern, scan_out, expected,
    output test_se, test_si, busy, done, response, fail
  );

  modport master (
    output start, pattern, scan_out, expected,
    input  test_se, test_si, busy, done, response, fail
  );
`else
  modport slave (
    input  start, pattern, scan_out,
    output test_se, test_si, busy, done, response
  );

  modport master (
    output start, pattern, scan_out,
    input  test_se, test_si, busy, done, response
  );
`endif
endinterface

// File: rtl/scan_test_ctrl.sv
// Scan test controller: shifts a latched pattern into a scan chain, pulses
// one capture cycle, then shifts the chain contents out into response.
// Optional macro SCAN_TEST_CTRL_COMPARE_EN adds expected/fail result check.
module scan_test_ctrl #(
  parameter int unsigned CHAIN_LEN = 14,
  parameter int unsigned CNT_W     = 4
) (
  input logic              CK,
  input logic              RN,
  scan_test_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     ridx;
  logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
  logic [CHAIN_LEN-1:0] response_q, response_d;
  logic                 test_se, test_si, busy, done;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected_q, expected_d;
  logic                 fail_q, fail_d;
`endif

  // State, counter, latched stimulus and captured response registers
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pattern_q  <= '0;
      response_q <= '0;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
      expected_q <= '0;
      fail_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pattern_q  <= pattern_d;
      response_q <= response_d;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
      expected_q <= expected_d;
      fail_q     <= fail_d;
`endif
    end
  end

  // Next-state and chain-control decode; the same reversed index walks the
  // pattern MSB-first during shift-in and fills response MSB-first on shift-out
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pattern_d  = pattern_q;
    response_d = response_q;
    test_se    = 1'b0;
    test_si    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ridx       = LAST - cnt_q;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
    expected_d = expected_q;
    fail_d     = fail_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pattern_d = bus.pattern;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
          expected_d = bus.expected;
`endif
          state_d = S_SHIFT_IN;
          cnt_d   = '0;
        end
      end

      S_SHIFT_IN: begin
        test_se = 1'b1;
        busy    = 1'b1;
        test_si = pattern_q[ridx];
        if (cnt_q == LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        busy    = 1'b1;
        state_d = S_SHIFT_OUT;
        cnt_d   = '0;
      end

      S_SHIFT_OUT: begin
        test_se          = 1'b1;
        busy             = 1'b1;
        response_d[ridx] = bus.scan_out;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
          // Evaluated on the final response so fail is valid throughout DONE
          fail_d = (response_d != expected_q);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        done  = 1'b1;
        cnt_d = '0;
        if (bus.start) begin
          pattern_d = bus.pattern;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
          expected_d = bus.expected;
`endif
          state_d = S_SHIFT_IN;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.test_se  = test_se;
  assign bus.test_si  = test_si;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.response = response_q;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
  assign bus.fail     = fail_q;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: behavioural scan chain (inverting or holding
// capture) plus a response scoreboard filled at start and drained at done.
module tb_scan_test_ctrl;
  localparam int unsigned CL = 14;

  typedef struct {
    logic [CL-1:0] resp;
    logic          fail;
  } sb_t;

  logic CK = 1'b0;
  logic RN;
  always #5 CK = ~CK;

  scan_test_ctrl_if #(.CHAIN_LEN(CL)) bus ();

  scan_test_ctrl #(.CHAIN_LEN(CL), .CNT_W(4)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  // Behavioural chain: position 0 nearest test_si, scan_out from position CL-1
  logic [CL-1:0] chain = '0;
  logic          inv_mode = 1'b1;
  always @(posedge CK) begin
    if (bus.test_se)   chain <= {chain[CL-2:0], bus.test_si};
    else if (inv_mode) chain <= ~chain;
  end
  assign bus.scan_out = chain[CL-1];

  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  int  exp_done = 0;
  int  busy_cnt = 0;
  logic prev_done = 1'b0;
  sb_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Output monitor: done pulse shape, busy length and scoreboard drain
  always @(negedge CK) begin
    if (!RN) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        sb_t e;
        done_cnt++;
        chk("done_1cyc", 32'(prev_done), 0);
        chk("done_busy", 32'(bus.busy), 0);
        chk("done_se", 32'(bus.test_se), 0);
        chk("busy_len", busy_cnt, 2*CL+1);
        chk("sb_nonempty", 32'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("response", 32'(bus.response), 32'(e.resp));
`ifdef SCAN_TEST_CTRL_COMPARE_EN
          chk("fail", 32'(bus.fail), 32'(e.fail));
`endif
        end
        busy_cnt = 0;
      end
      prev_done = bus.done;
    end
  end

  task automatic push_exp(input logic [CL-1:0] pat, input logic [CL-1:0] expv, input logic inv);
    sb_t e;
    e.resp = inv ? ~pat : pat;
    e.fail = (e.resp != expv);
    sbq.push_back(e);
  endtask

  task automatic start_test(input logic [CL-1:0] pat, input logic [CL-1:0] expv, input logic inv);
    @(negedge CK);
    inv_mode    = inv;
    bus.pattern = pat;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
    bus.expected = expv;
`endif
    bus.start = 1'b1;
    push_exp(pat, expv, inv);
    @(negedge CK);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int unsigned t = 0;
    while (done_cnt < target && t < 200) begin
      @(negedge CK);
      #1;
      t++;
    end
    chk("done_seen", 32'(done_cnt >= target), 1);
  endtask

  task automatic run_test(input logic [CL-1:0] pat, input logic [CL-1:0] expv, input logic inv);
    start_test(pat, expv, inv);
    exp_done++;
    wait_done(exp_done);
    repeat (2) @(negedge CK);
  endtask

  initial begin
    RN          = 1'b0;
    bus.start   = 1'b0;
    bus.pattern = '0;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
    bus.expected = '0;
`endif
    repeat (3) @(negedge CK);
    chk("rst_se", 32'(bus.test_se), 0);
    chk("rst_si", 32'(bus.test_si), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_resp", 32'(bus.response), 0);
`ifdef SCAN_TEST_CTRL_COMPARE_EN
    chk("rst_fail", 32'(bus.fail), 0);
`endif

    // Start presented together with reset release: taken on first rising edge
    RN          = 1'b1;
    inv_mode    = 1'b1;
    bus.pattern = 14'h2AAA;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
    bus.expected = 14'h1555;
`endif
    bus.start = 1'b1;
    push_exp(14'h2AAA, 14'h1555, 1'b1);
    @(negedge CK);
    bus.start = 1'b0;
    chk("first_accept", 32'(bus.busy), 1);
    exp_done++;
    wait_done(exp_done);
    repeat (4) @(negedge CK);
    chk("resp_stable", 32'(bus.response), 32'h1555);

    // Holding chain confirms bit order
    run_test(14'h0001, 14'h0001, 1'b0);
    run_test(14'h1234, 14'h1234, 1'b0);
    run_test(14'h0F0F, 14'h30F0, 1'b1);

    // Start during SHIFT_IN cycle 3 is ignored
    start_test(14'h2AAA, 14'h1555, 1'b1);
    exp_done++;
    repeat (3) @(negedge CK);
    bus.pattern = 14'h3FFF;
    bus.start   = 1'b1;
    @(negedge CK);
    bus.start = 1'b0;
    wait_done(exp_done);
    repeat (6) @(negedge CK);
    chk("ignored_start", done_cnt, exp_done);

    // Start held through DONE: next test begins immediately
    begin
      int unsigned t = 0;
      @(negedge CK);
      inv_mode    = 1'b1;
      bus.pattern = 14'h2AAA;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
      bus.expected = 14'h1555;
`endif
      bus.start = 1'b1;
      push_exp(14'h2AAA, 14'h1555, 1'b1);
      exp_done++;
      @(negedge CK);
      #1;
      while (!bus.done && t < 100) begin
        @(negedge CK);
        #1;
        t++;
      end
      chk("b2b_done_seen", 32'(bus.done), 1);
      bus.pattern = 14'h1234;
`ifdef SCAN_TEST_CTRL_COMPARE_EN
      bus.expected = 14'h2DCB;
`endif
      push_exp(14'h1234, 14'h2DCB, 1'b1);
      exp_done++;
      @(negedge CK);
      #1;
      bus.start = 1'b0;
      chk("b2b_busy", 32'(bus.busy), 1);
      wait_done(exp_done);
      repeat (3) @(negedge CK);
      chk("b2b_count", done_cnt, exp_done);
    end

    // Reset mid SHIFT_IN aborts with no done
    start_test(14'h1111, 14'h2EEE, 1'b1);
    repeat (4) @(negedge CK);
    #2;
    RN = 1'b0;
    #1;
    chk("abort_se", 32'(bus.test_se), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_resp", 32'(bus.response), 0);
    chk("abort_done", 32'(bus.done), 0);
    sbq.delete();
    repeat (2) @(negedge CK);
    #2;
    RN = 1'b1;
    repeat (40) @(negedge CK);
    chk("abort_no_done", done_cnt, exp_done);

    // Compare result: match then mismatch
    run_test(14'h2AAA, 14'h1555, 1'b1);
    run_test(14'h2AAA, 14'h1556, 1'b1);
`ifdef SCAN_TEST_CTRL_COMPARE_EN
    repeat (3) @(negedge CK);
    chk("fail_hold", 32'(bus.fail), 1);
`endif
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
